// File: rtl/y_chopper.sv
// y_chopper: vertical crop stage on the AXI-stream pixel path.
// Forwards lines [y_start, y_start+y_size) of each frame, re-encodes tuser
// sync codes (bit0 SOF, bit1 EOF, bit2 SOL, bit3 EOL) and flags malformed frames.
// Optional build macro Y_CHOPPER_SUBSAMPLE_EN adds aclk_y_skip for line subsampling.
module y_chopper #(
  parameter int DATA_W = 64,
  parameter int USER_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              aclk_reset,
  input  logic [CNT_W-1:0]  aclk_y_start,
  input  logic [CNT_W-1:0]  aclk_y_size,
  output logic              aclk_s_tready,
  input  logic              aclk_s_tvalid,
  input  logic [USER_W-1:0] aclk_s_tuser,
  input  logic              aclk_s_tlast,
  input  logic [DATA_W-1:0] aclk_s_tdata,
  input  logic              aclk_m_tready,
  output logic              aclk_m_tvalid,
  output logic [USER_W-1:0] aclk_m_tuser,
  output logic              aclk_m_tlast,
  output logic [DATA_W-1:0] aclk_m_tdata,
  output logic              aclk_frame_error
`ifdef Y_CHOPPER_SUBSAMPLE_EN
  ,
  input  logic [3:0]        aclk_y_skip
`endif
);

  localparam int WW = CNT_W + 2;

  typedef enum logic [1:0] {WAIT_SOF, KEEP, DROP, WAIT_SOL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] y_start_r;
  logic [CNT_W-1:0] y_size_r;
  logic [3:0]       skip_r;
  logic [3:0]       phase;
  logic             sent_any;
  logic             done;

  logic [3:0]       skip_in;
`ifdef Y_CHOPPER_SUBSAMPLE_EN
  assign skip_in = aclk_y_skip;
`else
  assign skip_in = '0;
`endif

  logic unused_tuser;
  assign unused_tuser = ^aclk_s_tuser;

  logic              acc, sof_beat, sol_beat, line_start, in_line;
  logic              s_eof, end_beat;
  logic [CNT_W-1:0]  cur_cnt, cur_start, cur_size, cnt_inc;
  logic [3:0]        cur_skip, cur_phase, phase_adv;
  logic              cur_sent, cur_done;
  logic [CNT_W:0]    win_end;
  logic [WW-1:0]     reach;
  logic              in_window, kept_now, keep_beat, last_kept_line, eof_emit;
  logic              err_next;
  logic [USER_W-1:0] user_out;

  // Stalled output only blocks input when the beat could be kept; a non-SOF beat
  // in DROP can never be kept, so it keeps flowing.
  assign aclk_s_tready = ~aclk_m_tvalid | aclk_m_tready |
                         ((state == DROP) & ~aclk_s_tuser[0]);

  // Per-beat decode: an SOF beat restarts the frame, so it sees fresh config and counters.
  always_comb begin
    acc        = aclk_s_tvalid & aclk_s_tready;
    s_eof      = aclk_s_tuser[1];
    sof_beat   = acc & aclk_s_tuser[0];
    sol_beat   = acc & ~aclk_s_tuser[0] & aclk_s_tuser[2] & (state == WAIT_SOL);
    line_start = sof_beat | sol_beat;
    in_line    = line_start |
                 (acc & ~aclk_s_tuser[0] & ((state == KEEP) | (state == DROP)));

    cur_cnt   = sof_beat ? '0 : cnt;
    cur_phase = sof_beat ? '0 : phase;
    cur_sent  = sof_beat ? 1'b0 : sent_any;
    cur_done  = sof_beat ? 1'b0 : done;
    cur_start = sof_beat ? aclk_y_start : y_start_r;
    cur_size  = sof_beat ? aclk_y_size  : y_size_r;
    cur_skip  = sof_beat ? skip_in      : skip_r;

    win_end        = {1'b0, cur_start} + {1'b0, cur_size};
    reach          = WW'(cur_cnt) + WW'(cur_skip) + WW'(1);
    in_window      = (cur_cnt >= cur_start) && ({1'b0, cur_cnt} < win_end);
    last_kept_line = reach >= {1'b0, win_end};
    kept_now       = line_start ? (in_window && (cur_phase == 4'd0)) : (state == KEEP);
    keep_beat      = in_line & kept_now;
    end_beat       = aclk_s_tlast | s_eof;
    eof_emit       = end_beat & (last_kept_line | s_eof);

    cnt_inc   = (cur_cnt == '1) ? cur_cnt : cur_cnt + 1'b1;
    phase_adv = (cur_phase == cur_skip) ? 4'd0 : cur_phase + 4'd1;

    user_out = '0;
    if (line_start) begin
      if (cur_sent) user_out[2] = 1'b1;
      else          user_out[0] = 1'b1;
    end
    if (end_beat) begin
      if (eof_emit) user_out[1] = 1'b1;
      else          user_out[3] = 1'b1;
    end

    err_next = (sof_beat & (state != WAIT_SOF)) |
               (in_line & ~kept_now & s_eof & cur_sent & ~cur_done);
  end

  // Frame/line FSM, counters and registered output stage.
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state            <= WAIT_SOF;
      cnt              <= '0;
      y_start_r        <= '0;
      y_size_r         <= '0;
      skip_r           <= '0;
      phase            <= '0;
      sent_any         <= 1'b0;
      done             <= 1'b0;
      aclk_m_tvalid    <= 1'b0;
      aclk_m_tuser     <= '0;
      aclk_m_tlast     <= 1'b0;
      aclk_m_tdata     <= '0;
      aclk_frame_error <= 1'b0;
    end else begin
      aclk_frame_error <= err_next;

      if (sof_beat) begin
        y_start_r <= aclk_y_start;
        y_size_r  <= aclk_y_size;
        skip_r    <= skip_in;
      end

      if (in_line) begin
        sent_any <= cur_sent | keep_beat;
        done     <= cur_done | (keep_beat & eof_emit);
        cnt      <= aclk_s_tlast ? cnt_inc : cur_cnt;
        phase    <= (aclk_s_tlast && in_window) ? phase_adv : cur_phase;
        if (s_eof)             state <= WAIT_SOF;
        else if (aclk_s_tlast) state <= WAIT_SOL;
        else if (kept_now)     state <= KEEP;
        else                   state <= DROP;
      end else if (acc && s_eof) begin
        state <= WAIT_SOF;
      end

      if (keep_beat) begin
        aclk_m_tvalid <= 1'b1;
        aclk_m_tuser  <= user_out;
        aclk_m_tlast  <= aclk_s_tlast;
        aclk_m_tdata  <= aclk_s_tdata;
      end else if (aclk_m_tready) begin
        aclk_m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_y_chopper.sv
// tb_y_chopper: randomized self-checking bench for y_chopper with a frame-level model.
module tb_y_chopper;

  localparam int DW = 64;
  localparam int UW = 4;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          aclk_reset;
  logic [CW-1:0] aclk_y_start, aclk_y_size;
  logic          s_tready, s_tvalid, s_tlast;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] s_tdata;
  logic          m_tready, m_tvalid, m_tlast;
  logic [UW-1:0] m_tuser;
  logic [DW-1:0] m_tdata;
  logic          frame_error;
  logic [3:0]    y_skip;

  y_chopper #(.DATA_W(DW), .USER_W(UW), .CNT_W(CW)) dut (
    .aclk(aclk), .aclk_reset(aclk_reset),
    .aclk_y_start(aclk_y_start), .aclk_y_size(aclk_y_size),
    .aclk_s_tready(s_tready), .aclk_s_tvalid(s_tvalid), .aclk_s_tuser(s_tuser),
    .aclk_s_tlast(s_tlast), .aclk_s_tdata(s_tdata),
    .aclk_m_tready(m_tready), .aclk_m_tvalid(m_tvalid), .aclk_m_tuser(m_tuser),
    .aclk_m_tlast(m_tlast), .aclk_m_tdata(m_tdata),
    .aclk_frame_error(frame_error)
`ifdef Y_CHOPPER_SUBSAMPLE_EN
    , .aclk_y_skip(y_skip)
`endif
  );

  initial forever #5 aclk = ~aclk;

  typedef logic [DW+UW:0] beat_t;  // {tlast, tuser, tdata}
  beat_t exp_q[$];
  beat_t got_q[$];

  int checks = 0, passed = 0;
  int err_cnt = 0, stall_cnt = 0, sready_low = 0;
  int ready_mode = 0, gap_pct = 0;
  logic [DW-1:0] ramp_val;

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge aclk);
    if (!aclk_reset) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tuser, m_tdata});
      if (frame_error) err_cnt++;
      if (m_tready && !s_tready) stall_cnt++;
      if (!s_tready) sready_low++;
    end
  end

  // Downstream ready: always-on or random 50%.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Reference rules: which frame lines survive, and the last line of the full window.
  function automatic bit kept(int l, int ys, int ysz, int sk);
    return (l >= ys) && (l < ys + ysz) && (((l - ys) % (sk + 1)) == 0);
  endfunction

  function automatic int last_win(int ys, int ysz, int sk);
    if (ysz == 0) return -1;
    return ys + ((ysz - 1) / (sk + 1)) * (sk + 1);
  endfunction

  function automatic int frame_err_exp(int nl, int ys, int ysz, int sk);
    bit any = 0;
    for (int l = 0; l < nl; l++) if (kept(l, ys, ysz, sk)) any = 1;
    return (any && last_win(ys, ysz, sk) > nl - 1 && !kept(nl - 1, ys, ysz, sk)) ? 1 : 0;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic clear_all();
    got_q.delete(); exp_q.delete();
    err_cnt = 0; stall_cnt = 0; sready_low = 0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    bit acc = 0;
    int waited = 0;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      s_tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    while (!acc) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk); #1;
      waited++;
      if (!acc && waited > 2000) begin
        checks++;
        $display("FAIL handshake_timeout: s_tready low for %0d cycles, required 1", waited);
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "input handshake stuck");
      end
    end
    s_tvalid = 1'b0;
  endtask

  // Sends one frame; stop_beats >= 0 aborts after that many beats (no EOF sent).
  task automatic send_frame(input int nl, input int nb, input int ys, input int ysz,
                            input int sk, input bit ramp, input int stop_beats);
    bit seen = 0;
    int sent = 0;
    int lw = last_win(ys, ysz, sk);
    logic [UW-1:0] u, eu;
    logic [DW-1:0] d;
    aclk_y_start = CW'(ys); aclk_y_size = CW'(ysz); y_skip = 4'(sk);
    ramp_val = '0;
    for (int l = 0; l < nl; l++) begin
      for (int j = 0; j < nb; j++) begin
        if (stop_beats >= 0 && sent == stop_beats) return;
        u = '0;
        if (j == 0) u = (l == 0) ? 4'b0001 : 4'b0100;
        if (j == nb - 1) u = u | ((l == nl - 1) ? 4'b0010 : 4'b1000);
        d = ramp ? ramp_val : {$urandom, $urandom};
        ramp_val = ramp_val + 1;
        if (kept(l, ys, ysz, sk)) begin
          eu = '0;
          if (j == 0) eu = seen ? 4'b0100 : 4'b0001;
          seen = 1;
          if (j == nb - 1) eu = eu | ((l == lw || l == nl - 1) ? 4'b0010 : 4'b1000);
          exp_q.push_back({(j == nb - 1), eu, d});
        end
        drive_beat(d, u, (j == nb - 1));
        sent++;
        if (sent == 1) begin
          // config must have been captured on the SOF beat
          aclk_y_start = CW'($urandom); aclk_y_size = CW'($urandom); y_skip = 4'($urandom);
        end
      end
    end
  endtask

  task automatic wait_drain(output bit to);
    int n = 0;
    repeat (3) @(negedge aclk);
    while (!(got_q.size() >= exp_q.size() && !m_tvalid) && n < 3000) begin
      @(negedge aclk); n++;
    end
    repeat (2) @(negedge aclk);
    to = (n >= 3000);
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    aclk_reset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid); else passed++;
    checks++; if ({m_tlast, m_tuser, m_tdata} !== '0) $display("FAIL reset_m_bus: got %h, required 0", {m_tlast, m_tuser, m_tdata}); else passed++;
    checks++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error: got %b, required 0", frame_error); else passed++;
    checks++; if (s_tready !== 1'b1) $display("FAIL reset_s_tready: got %b, required 1", s_tready); else passed++;
    @(posedge aclk); #1;
    aclk_reset = 1'b0;
    clear_all();
  endtask

  task automatic test_window(input int rm);
    bit to;
    int d;
    clear_all();
    ready_mode = rm; gap_pct = 0;
    send_frame(8, 128, 2, 3, 0, 1'b1, -1);
    wait_drain(to);
    checks++; if (to) $display("FAIL win_drain_timeout: got %0d beats, required %0d", got_q.size(), exp_q.size()); else passed++;
    checks++; if (got_q.size() !== 384) $display("FAIL win_count: got %0d beats, required 384", got_q.size()); else passed++;
    d = first_diff();
    checks++; if (d !== -1) $display("FAIL win_seq: beat %0d got %h, required %h", d, got_q[d], exp_q[d]); else passed++;
    if (got_q.size() >= 384) begin
      checks++; if (got_q[0] !== {1'b0, 4'b0001, 64'd256}) $display("FAIL win_first_beat: got %h, required sof data 256", got_q[0]); else passed++;
      checks++; if (got_q[127][DW+UW:DW] !== 5'b11000) $display("FAIL win_line2_end: got %b, required 11000", got_q[127][DW+UW:DW]); else passed++;
      checks++; if (got_q[383][DW+UW:DW] !== 5'b10010) $display("FAIL win_line4_end: got %b, required 10010", got_q[383][DW+UW:DW]); else passed++;
    end
    checks++; if (err_cnt !== 0) $display("FAIL win_error: got %0d pulses, required 0", err_cnt); else passed++;
    if (rm == 0) begin
      checks++; if (stall_cnt !== 0) $display("FAIL win_bubbles: got %0d stalls, required 0", stall_cnt); else passed++;
    end
  endtask

  task automatic test_empty();
    bit to;
    clear_all();
    ready_mode = 1; gap_pct = 0;
    send_frame(8, 16, 1, 0, 0, 1'b0, -1);
    wait_drain(to);
    checks++; if (got_q.size() !== 0) $display("FAIL empty_count: got %0d beats, required 0", got_q.size()); else passed++;
    checks++; if (sready_low !== 0) $display("FAIL empty_s_tready: got %0d low cycles, required 0", sready_low); else passed++;
    checks++; if (err_cnt !== 0) $display("FAIL empty_error: got %0d pulses, required 0", err_cnt); else passed++;
    clear_all();
    send_frame(4, 4, 16'hFFFE, 4, 0, 1'b0, -1);
    wait_drain(to);
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL wrap_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_short_frame();
    bit to;
    int d;
    clear_all();
    ready_mode = 1; gap_pct = 10;
    send_frame(4, 10, 2, 5, 0, 1'b0, -1);
    wait_drain(to);
    checks++; if (got_q.size() !== 20) $display("FAIL short_count: got %0d beats, required 20", got_q.size()); else passed++;
    d = first_diff();
    checks++; if (d !== -1) $display("FAIL short_seq: beat %0d got %h, required %h", d, got_q[d], exp_q[d]); else passed++;
    if (got_q.size() == 20) begin
      checks++; if (got_q[19][DW+UW-1:DW] !== 4'b0010) $display("FAIL short_eof: got %b, required 0010", got_q[19][DW+UW-1:DW]); else passed++;
    end
    checks++; if (err_cnt !== 0) $display("FAIL short_error: got %0d pulses, required 0", err_cnt); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int d;
    ready_mode = 1; gap_pct = 0;
    send_frame(8, 16, 0, 8, 0, 1'b0, 3 * 16 + 5);
    aclk_reset = 1'b1;
    @(posedge aclk); #1;
    aclk_reset = 1'b0;
    clear_all();
    for (int i = 0; i < 3; i++) drive_beat({$urandom, $urandom}, 4'b0000, (i == 2));
    send_frame(4, 16, 0, 2, 0, 1'b0, -1);
    wait_drain(to);
    checks++; if (got_q.size() !== 32) $display("FAIL rst_count: got %0d beats, required 32", got_q.size()); else passed++;
    d = first_diff();
    checks++; if (d !== -1) $display("FAIL rst_seq: beat %0d got %h, required %h", d, got_q[d], exp_q[d]); else passed++;
    checks++; if (err_cnt !== 0) $display("FAIL rst_error: got %0d pulses, required 0", err_cnt); else passed++;
  endtask

  task automatic test_resync();
    bit to;
    int d;
    clear_all();
    ready_mode = 1; gap_pct = 0;
    send_frame(6, 8, 0, 0, 0, 1'b0, 3 * 8);
    send_frame(5, 8, 1, 2, 0, 1'b0, -1);
    wait_drain(to);
    checks++; if (err_cnt !== 1) $display("FAIL resync_error: got %0d pulses, required 1", err_cnt); else passed++;
    checks++; if (got_q.size() !== 16) $display("FAIL resync_count: got %0d beats, required 16", got_q.size()); else passed++;
    d = first_diff();
    checks++; if (d !== -1) $display("FAIL resync_seq: beat %0d got %h, required %h", d, got_q[d], exp_q[d]); else passed++;
  endtask

  task automatic test_random();
    bit to;
    int d, exp_err = 0;
    int nl, nb, ys, ysz, sk;
    clear_all();
    ready_mode = 1; gap_pct = 20;
    for (int f = 0; f < 24; f++) begin
      nl = $urandom_range(1, 6); nb = $urandom_range(1, 5);
      ys = $urandom_range(0, 6); ysz = $urandom_range(0, 6); sk = 0;
`ifdef Y_CHOPPER_SUBSAMPLE_EN
      sk = $urandom_range(0, 3);
`endif
      exp_err += frame_err_exp(nl, ys, ysz, sk);
      send_frame(nl, nb, ys, ysz, sk, 1'b0, -1);
    end
    wait_drain(to);
    checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); else passed++;
    d = first_diff();
    checks++; if (d !== -1) $display("FAIL rand_seq: beat %0d got %h, required %h", d, got_q[d], exp_q[d]); else passed++;
    checks++; if (err_cnt !== exp_err) $display("FAIL rand_error: got %0d pulses, required %0d", err_cnt, exp_err); else passed++;
  endtask

`ifdef Y_CHOPPER_SUBSAMPLE_EN
  task automatic test_subsample();
    bit to;
    int d;
    clear_all();
    ready_mode = 1; gap_pct = 0;
    send_frame(8, 8, 0, 5, 1, 1'b0, -1);
    wait_drain(to);
    checks++; if (got_q.size() !== 24) $display("FAIL sub_count: got %0d beats, required 24", got_q.size()); else passed++;
    d = first_diff();
    checks++; if (d !== -1) $display("FAIL sub_seq: beat %0d got %h, required %h", d, got_q[d], exp_q[d]); else passed++;
    if (got_q.size() == 24) begin
      checks++; if (got_q[23][DW+UW-1:DW] !== 4'b0010) $display("FAIL sub_eof: got %b, required 0010", got_q[23][DW+UW-1:DW]); else passed++;
    end
    clear_all();
    send_frame(4, 8, 0, 5, 1, 1'b0, -1);
    wait_drain(to);
    checks++; if (err_cnt !== 1) $display("FAIL sub_short_error: got %0d pulses, required 1", err_cnt); else passed++;
    checks++; if (got_q.size() !== 16) $display("FAIL sub_short_count: got %0d beats, required 16", got_q.size()); else passed++;
  endtask
`endif

  initial begin
    aclk_reset = 1'b1; s_tvalid = 1'b0; s_tuser = '0; s_tlast = 1'b0; s_tdata = '0;
    aclk_y_start = '0; aclk_y_size = '0; y_skip = '0;
    test_reset();
    test_window(0);
    test_window(1);
    test_empty();
    test_short_frame();
    test_reset_mid_frame();
    test_resync();
    test_random();
`ifdef Y_CHOPPER_SUBSAMPLE_EN
    test_subsample();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
